// File: rtl/dm_timer_pkg.sv
// dm_timer_pkg: shared definitions for the memory-mapped countdown timer.
//   - register offsets decoded from A[3:2]
//   - CTRL field layout and mode codes
//   - FSM state encoding
package dm_timer_pkg;

  // Register offsets (word index within the 16-byte window)
  localparam logic [1:0] TMR_CTRL     = 2'd0;
  localparam logic [1:0] TMR_PRESET   = 2'd1;
  localparam logic [1:0] TMR_COUNT    = 2'd2;
  localparam logic [1:0] TMR_PRESCALE = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;
  localparam int unsigned CTRL_W        = 4;

  // Mode codes; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // Field order matches the CTRL bit positions above (im=3, mode=2:1, en=0)
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

endpackage

// File: rtl/dm_timer_regs.sv
// dm_timer_regs: software-visible register file of the timer.
//   Holds CTRL, PRESET and (with DM_TIMER_PRESCALE_EN) PRESCALE, decodes
//   stores and drives the combinational load-data mux.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   sel_i, we_i, addr_i   chip select, store strobe, word offset A[3:2]
//   wd_i                  store data
//   count_i               live COUNT value from the FSM (read-only view)
//   fsm_en_clr_i          FSM request to clear CTRL.en (one-shot expiry)
//   rd_o                  load data, 0 when not selected
//   ctrl_o / ctrl_d_o     current / next-edge CTRL value
//   ctrl_wr_o             store to CTRL accepted this cycle
//   preset_o              PRESET register
//   prescale_o            PRESCALE register (only with DM_TIMER_PRESCALE_EN)
module dm_timer_regs
  import dm_timer_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sel_i,
  input  logic                  we_i,
  input  logic [1:0]            addr_i,
  input  logic [31:0]           wd_i,
  input  logic [COUNT_W-1:0]    count_i,
  input  logic                  fsm_en_clr_i,
  output logic [31:0]           rd_o,
  output tmr_ctrl_t             ctrl_o,
  output tmr_ctrl_t             ctrl_d_o,
  output logic                  ctrl_wr_o,
`ifdef DM_TIMER_PRESCALE_EN
  output logic [PRESCALE_W-1:0] prescale_o,
`endif
  output logic [COUNT_W-1:0]    preset_o
);

  logic                 wr_en;
  tmr_ctrl_t            ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;

  assign wr_en     = sel_i & we_i;
  assign ctrl_wr_o = wr_en && (addr_i == TMR_CTRL);

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (fsm_en_clr_i) ctrl_d.en = 1'b0;
    // CPU store overrides a same-edge FSM clear of en
    if (ctrl_wr_o) ctrl_d = tmr_ctrl_t'(wd_i[CTRL_W-1:0]);
    if (wr_en && (addr_i == TMR_PRESET)) preset_d = wd_i[COUNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

`ifdef DM_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  always_comb begin
    prescale_d = prescale_q;
    if (wr_en && (addr_i == TMR_PRESCALE)) prescale_d = wd_i[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) prescale_q <= '0;
    else         prescale_q <= prescale_d;
  end

  assign prescale_o = prescale_q;
`endif

  always_comb begin
    rd_o = '0;
    if (sel_i) begin
      unique case (addr_i)
        TMR_CTRL:   rd_o[CTRL_W-1:0]  = ctrl_q;
        TMR_PRESET: rd_o[COUNT_W-1:0] = preset_q;
        TMR_COUNT:  rd_o[COUNT_W-1:0] = count_i;
`ifdef DM_TIMER_PRESCALE_EN
        TMR_PRESCALE: rd_o[PRESCALE_W-1:0] = prescale_q;
`else
        TMR_PRESCALE: rd_o = '0;
`endif
        default:    rd_o = '0;
      endcase
    end
  end

  assign ctrl_o   = ctrl_q;
  assign ctrl_d_o = ctrl_d;
  assign preset_o = preset_q;

endmodule

// File: rtl/dm_timer.sv
// dm_timer: memory-mapped countdown timer on the CPU data-memory port.
//   The register file lives in dm_timer_regs; this file holds the
//   IDLE/LOAD/CNT/INT FSM, the COUNT register, the interrupt flag and irq.
//   Optional macro DM_TIMER_PRESCALE_EN adds a PRESCALE register and a
//   divider that slows COUNT stepping by (PRESCALE+1).
// Ports:
//   clk    system clock          reset  synchronous, active-low
//   sel    chip select           WE     store strobe (qualified by sel)
//   A      byte address, A[3:2]  WD     store data
//   pc     M-stage PC (store trace only)
//   RD     combinational load data, 0 when sel=0
//   irq    registered interrupt request
module dm_timer
  import dm_timer_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [31:0] pc,
  output logic [31:0] RD,
  output logic        irq
);

  tmr_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               int_flag_q, int_flag_d;
  logic               irq_q;
  logic               fsm_en_clr;
  logic               tick;
  tmr_ctrl_t          ctrl, ctrl_nxt;
  logic               ctrl_wr;
  logic [COUNT_W-1:0] preset;
  logic [29:0]        addr_unused;

  assign addr_unused = {A[31:4], A[1:0]};

`ifdef DM_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] div_q, div_d;
`endif

  dm_timer_regs #(
    .COUNT_W    (COUNT_W),
    .PRESCALE_W (PRESCALE_W)
  ) u_regs (
    .clk_i        (clk),
    .rst_ni       (reset),
    .sel_i        (sel),
    .we_i         (WE),
    .addr_i       (A[3:2]),
    .wd_i         (WD),
    .count_i      (count_q),
    .fsm_en_clr_i (fsm_en_clr),
    .rd_o         (RD),
    .ctrl_o       (ctrl),
    .ctrl_d_o     (ctrl_nxt),
    .ctrl_wr_o    (ctrl_wr),
`ifdef DM_TIMER_PRESCALE_EN
    .prescale_o   (prescale),
`endif
    .preset_o     (preset)
  );

`ifdef DM_TIMER_PRESCALE_EN
  assign tick = (div_q == '0);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;
    fsm_en_clr = 1'b0;
`ifdef DM_TIMER_PRESCALE_EN
    div_d      = div_q;
`endif
    // A CTRL store clears the flag; a same-edge set below takes priority
    if (ctrl_wr) int_flag_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // en dropped by an earlier store: abandon the reload
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else begin
          count_d = preset;
`ifdef DM_TIMER_PRESCALE_EN
          div_d   = prescale;
`endif
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q == '0) begin
            state_d    = ST_INT;
            int_flag_d = 1'b1;
          end else begin
            count_d = count_q - COUNT_W'(1);
          end
`ifdef DM_TIMER_PRESCALE_EN
          div_d = prescale;
`endif
        end else begin
`ifdef DM_TIMER_PRESCALE_EN
          div_d = div_q - PRESCALE_W'(1);
`endif
        end
      end
      ST_INT: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (ctrl.mode == MODE_AUTO) begin
          state_d    = ST_LOAD;
          int_flag_d = 1'b0;
        end else begin
          fsm_en_clr = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      int_flag_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef DM_TIMER_PRESCALE_EN
      div_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
      // Built from next-edge values so irq tracks int_flag & im exactly
      irq_q      <= int_flag_d & ctrl_nxt.im;
`ifdef DM_TIMER_PRESCALE_EN
      div_q      <= div_d;
`endif
    end
  end

  assign irq = irq_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && sel && WE) $display("@%h: *%h <= %h", pc, A, WD);
  end
`endif

endmodule

// File: tb/tb_dm_timer.sv
// tb_dm_timer: directed self-checking bench for dm_timer.
module tb_dm_timer;
  import dm_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] pc;
  logic [31:0] RD;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dm_timer #(
    .COUNT_W    (32),
    .PRESCALE_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .pc    (pc),
    .RD    (RD),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    sel = 1'b1; WE = 1'b1; A = {28'd0, off, 2'b00}; WD = d; pc = pc + 32'd4;
    tick();
    sel = 1'b0; WE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] off, input logic [31:0] exp);
    sel = 1'b1; WE = 1'b0; A = {28'd0, off, 2'b00};
    #1;
    check_eq(tag, RD, exp);
    sel = 1'b0;
  endtask

  task automatic irq_check(input string tag, input logic exp);
    check_eq(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; WE = 1'b0; A = '0; WD = '0; pc = 32'h0000_3000;

    // ---------------- reset ----------------
    repeat (2) tick();
    sel = 1'b1; WE = 1'b1; A = 32'h4; WD = 32'h55;
    tick();
    sel = 1'b0; WE = 1'b0;
    reset = 1'b1;
    for (int unsigned i = 0; i < 4; i++) rd_check("rst_rd", 2'(i), 32'h0);
    irq_check("rst_irq", 1'b0);

    // ---------------- one-shot ----------------
    wr(TMR_PRESET, 32'd5);
    wr(TMR_CTRL, 32'h9);                 // edge t
    repeat (2) tick();                   // after t+2
    rd_check("os_cnt5", TMR_COUNT, 32'd5);
    repeat (5) tick();                   // after t+7
    rd_check("os_cnt0", TMR_COUNT, 32'd0);
    irq_check("os_irq_t7", 1'b0);
    tick();                              // after t+8
    irq_check("os_irq_t8", 1'b1);
    tick();                              // after t+9
    rd_check("os_ctrl8", TMR_CTRL, 32'h8);
    repeat (3) tick();
    irq_check("os_irq_hold", 1'b1);
    rd_check("os_cnt_hold", TMR_COUNT, 32'd0);
    wr(TMR_CTRL, 32'h0);
    irq_check("os_irq_clr", 1'b0);

    // ---------------- auto-reload ----------------
    wr(TMR_PRESET, 32'd2);
    wr(TMR_CTRL, 32'hB);                 // edge t
    for (int unsigned k = 1; k <= 15; k++) begin
      tick();                            // after t+k
      irq_check("ar_irq", (k % 5) == 0);
      if (k >= 2) begin
        int unsigned ph;
        ph = (k - 2) % 5;
        rd_check("ar_cnt", TMR_COUNT, (ph < 3) ? 32'(2 - ph) : 32'd0);
      end
    end
    wr(TMR_CTRL, 32'h0);
    irq_check("ar_stop_irq", 1'b0);

    // ---------------- disable mid-count ----------------
    wr(TMR_PRESET, 32'd100);
    wr(TMR_CTRL, 32'h1);                 // edge t
    repeat (11) tick();                  // after t+11
    rd_check("dis_cnt91", TMR_COUNT, 32'd91);
    wr(TMR_CTRL, 32'h0);                 // edge t+12
    rd_check("dis_cnt90a", TMR_COUNT, 32'd90);
    repeat (4) tick();
    rd_check("dis_cnt90b", TMR_COUNT, 32'd90);
    wr(TMR_COUNT, 32'd7);
    rd_check("dis_cnt_ro", TMR_COUNT, 32'd90);
    irq_check("dis_irq", 1'b0);
    rd_check("dis_ctrl", TMR_CTRL, 32'h0);

    // ---------------- masking / PRESET=0 ----------------
    wr(TMR_PRESET, 32'd0);
    wr(TMR_CTRL, 32'h1);                 // edge t
    repeat (2) tick();                   // after t+2
    rd_check("msk_cnt0", TMR_COUNT, 32'd0);
    tick();                              // after t+3: INT
    irq_check("msk_irq_int", 1'b0);
    rd_check("msk_ctrl_int", TMR_CTRL, 32'h1);
    tick();                              // after t+4: IDLE, en cleared
    rd_check("msk_ctrl_idle", TMR_CTRL, 32'h0);
    wr(TMR_CTRL, 32'h9);                 // edge u
    irq_check("msk_irq_u", 1'b0);
    repeat (2) tick();
    irq_check("msk_irq_u2", 1'b0);
    tick();                              // after u+3
    irq_check("msk_irq_u3", 1'b1);
    tick();
    rd_check("msk_ctrl_u4", TMR_CTRL, 32'h8);

    // ---------------- stores ignored when sel=0 ----------------
    sel = 1'b0; WE = 1'b1; A = {28'd0, TMR_CTRL, 2'b00}; WD = 32'h0;
    #1;
    check_eq("nosel_rd0", RD, 32'h0);
    tick();
    A = {28'd0, TMR_PRESET, 2'b00}; WD = 32'h1234;
    tick();
    WE = 1'b0;
    rd_check("nosel_ctrl", TMR_CTRL, 32'h8);
    rd_check("nosel_preset", TMR_PRESET, 32'h0);
    irq_check("nosel_irq", 1'b1);

    // ---------------- reset mid-count ----------------
    wr(TMR_PRESET, 32'd20);
    wr(TMR_CTRL, 32'hB);
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    irq_check("mrst_irq", 1'b0);
    rd_check("mrst_cnt", TMR_COUNT, 32'h0);
    rd_check("mrst_ctrl", TMR_CTRL, 32'h0);
    rd_check("mrst_preset", TMR_PRESET, 32'h0);
    repeat (3) tick();
    rd_check("mrst_cnt_idle", TMR_COUNT, 32'h0);

`ifdef DM_TIMER_PRESCALE_EN
    // ---------------- prescaler ----------------
    wr(TMR_PRESCALE, 32'd3);
    rd_check("ps_reg", TMR_PRESCALE, 32'd3);
    wr(TMR_PRESET, 32'd2);
    wr(TMR_CTRL, 32'h9);                 // edge t, LOAD entered at t+1
    for (int unsigned k = 1; k <= 14; k++) begin
      tick();
      if (k == 5)  rd_check("ps_cnt2", TMR_COUNT, 32'd2);
      if (k == 6)  rd_check("ps_cnt1", TMR_COUNT, 32'd1);
      if (k == 10) rd_check("ps_cnt0", TMR_COUNT, 32'd0);
      if (k == 13) irq_check("ps_irq13", 1'b0);
      if (k == 14) irq_check("ps_irq14", 1'b1);
    end
`else
    // ---------------- offset 3 absent ----------------
    wr(TMR_PRESCALE, 32'h55);
    rd_check("ps_absent", TMR_PRESCALE, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_timer.md
Name: dm_timer

Overview:
- Memory-mapped countdown timer. It is the responder on the CPU data-memory port; the pipeline's M stage is the initiator.
- An external address decoder asserts sel for the timer's 16-byte window. The block then decodes A[3:2], accepts stores, and returns load data combinationally in the same cycle, the same way DM does.
- An internal FSM loads, counts down and raises irq to the CPU.

Parameters:
- COUNT_W, 32, width of PRESET/COUNT registers (≤32; zero-extended on reads)
- PRESCALE_W, 8, width of PRESCALE register (used only with DM_TIMER_PRESCALE_EN)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-low: reset=0 at a posedge resets the block
- sel  input  1  chip select from address decoder (M stage)
- WE  input  1  store strobe; effective only when sel=1
- A  input  32  byte address; only A[3:2] used
- WD  input  32  store data
- pc  input  32  PC of the M-stage instruction; debug display only
- RD  output  32  load data, combinational from A[3:2] and the registers; 0 when sel=0
- irq  output  1  interrupt request to CPU

Behaviour:
- Register map (A[3:2]):
  - 0 CTRL: [0] en, [2:1] mode (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] im. Other bits read 0.
  - 1 PRESET, read/write.
  - 2 COUNT, read-only; writes ignored.
  - 3 PRESCALE with the macro, else reads 0 and writes ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0, irq=0. RD reads 0 for all offsets after reset.
- Writes: take effect at the posedge with sel&WE&reset. Write to CTRL clears int_flag.
- A PRESET write during counting affects only the next LOAD.
- irq = int_flag & CTRL.im, registered, no combinational path from WD.
- FSM states and transitions, each evaluated at a posedge:
  - IDLE: CTRL.en=1 → LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - CTRL.en=0 → IDLE, COUNT held.
    - COUNT==0 → INT, int_flag<=1.
    - Otherwise COUNT<=COUNT-1.
  - INT, one-shot: CTRL.en<=0 → IDLE; int_flag stays set until the next CTRL write.
  - INT, auto-reload: → LOAD; int_flag cleared at that edge, giving a one-cycle irq pulse.
- Latency: CTRL.en write at edge t with PRESET=N gives LOAD at t+1, COUNT=N at t+2, COUNT=0 at t+2+N, and INT plus irq high after edge t+3+N.
- PRESET=0: the CNT state lasts one cycle, then INT.
- Simultaneous events:
  - A CPU CTRL write at the same edge as an FSM-driven CTRL.en clear in INT: the CPU value wins.
  - A CTRL write with en=0 in any state forces IDLE at the next edge.
  - A CTRL write in INT clears int_flag. A new int_flag set at the same edge wins over the clear.
- Reset asserted mid-count: all state returns to reset values at that edge. No irq glitch; irq is 0 after the edge.
- COUNT arithmetic: wraps only through LOAD; decrement never occurs at 0.
- Each accepted store prints one line "@%h: *%h <= %h" (pc, A, WD) via $display, like the other writable state.

Optional Feature:
- DM_TIMER_PRESCALE_EN defined:
  - PRESCALE register at offset 3, reset value 0.
  - An internal PRESCALE_W-bit divider reloads with PRESCALE in LOAD.
  - In CNT, COUNT decrements (and the COUNT==0 check applies) only on cycles where the divider is 0; the divider then reloads, otherwise it decrements.
  - PRESCALE=0 gives behaviour identical to the macro being undefined.
- DM_TIMER_PRESCALE_EN undefined: no divider logic; offset 3 reads 0; COUNT steps every CNT cycle.

Decomposition:
- Shared package/header: register offsets (TMR_CTRL=2'd0, TMR_PRESET=2'd1, TMR_COUNT=2'd2, TMR_PRESCALE=2'd3), CTRL bit positions, mode codes, FSM state encodings (IDLE/LOAD/CNT/INT, 2 bits).
- One natural sub-module, dm_timer_regs: register file, write decode, RD mux.
- FSM and counter stay in dm_timer.

Test Plan:
- Reset: hold reset=0 two cycles, read offsets 0-3 → RD=0, irq=0; a store during reset has no effect.
- One-shot: write PRESET=5, then CTRL=0x9 (en, im) at edge t → COUNT reads 5 after t+2, reads 0 after t+7; irq=1 after t+8; CTRL reads 0x8; irq stays 1 until a CTRL write of 0 clears it.
- Auto-reload: PRESET=2, CTRL=0xB → irq pulses exactly one cycle every 5 cycles (LOAD + 3 CNT + INT); COUNT cycles 2,1,0.
- Disable mid-count: PRESET=100; after 10 CNT cycles write CTRL=0 → COUNT freezes at 90, state IDLE, irq never asserts; write COUNT=7 → COUNT still reads 90.
- Masking/edge cases: PRESET=0, CTRL=0x1 (im=0) → INT reached 3 cycles after the write edge with irq=0. Then CTRL=0x9 → clears flag, recount, irq=1. With sel=0 and WE=1, stores are ignored.
- With DM_TIMER_PRESCALE_EN: PRESCALE=3, PRESET=2 → COUNT steps every 4 cycles; irq 13 cycles after the LOAD edge. PRESCALE=0 → timing identical to the macro-off build.
